// File: rtl/symbol_serializer.sv
// Serializes encoded line symbols onto a single bit stream, one symbol per SYMBOL_W cycles,
// inserting IDLE_SYMBOL whenever no data symbol is waiting at a symbol boundary.
module symbol_serializer #(
  parameter int                    SYMBOL_W    = 10,
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter logic [SYMBOL_W-1:0]   IDLE_SYMBOL = 10'b0011111010
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [SYMBOL_W-1:0] symbol_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                serial_o,
  output logic                symbol_start_o,
  output logic                underrun_o,
  output logic [15:0]         underrun_count_o
);

  localparam int              CNT_W = (SYMBOL_W > 1) ? $clog2(SYMBOL_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_W - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [SYMBOL_W-1:0] hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [SYMBOL_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                underrun_q, underrun_d;
  logic [15:0]         count_q, count_d;

  logic at_last;
  logic load_now;
  logic transfer;

  // load_now is built from registered state and en_i only, so ready_o never sees valid_i.
  assign at_last  = (cnt_q == LAST);
  assign load_now = en_i && ((state_q == S_IDLE) || at_last);
  assign transfer = valid_i && ready_o;

  // NOTE: every flop uses <= so all registers update together from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en_i)              state_d = S_RUN;
      S_RUN:   if (at_last && !en_i)  state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    underrun_d   = 1'b0;
    count_d      = count_q;

    if (load_now) begin
      cnt_d = '0;
      if (hold_valid_q) begin
        shift_d      = hold_q;
        hold_valid_d = 1'b0;
      end else begin
        shift_d    = IDLE_SYMBOL;
        underrun_d = 1'b1;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
    end else if (state_q == S_RUN && !at_last) begin
      shift_d = MSB_FIRST ? {shift_q[SYMBOL_W-2:0], 1'b0} : {1'b0, shift_q[SYMBOL_W-1:1]};
      cnt_d   = cnt_q + CNT_W'(1);
    end

    // A transfer on a load edge refills the buffer after the old contents left.
    if (transfer) begin
      hold_d       = symbol_i;
      hold_valid_d = 1'b1;
    end
  end

  // NOTE: the hold buffer is a single register, so it is cleared on reset along with the rest.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      underrun_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      underrun_q   <= underrun_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    ready_o        = !hold_valid_q || load_now;
    serial_o       = 1'b0;
    symbol_start_o = 1'b0;
    if (state_q == S_RUN) begin
      serial_o       = MSB_FIRST ? shift_q[SYMBOL_W-1] : shift_q[0];
      symbol_start_o = (cnt_q == '0);
    end
  end

  assign underrun_o       = underrun_q;
  assign underrun_count_o = count_q;

endmodule
